// File: rtl/decoder_3to8_pkg.sv
// Shared types and helpers for the 3-to-8 link decoder.
package dec_pkg;

  localparam int CODE_W = 3;
  localparam int LINE_W = 8;

  typedef logic [CODE_W-1:0] code_t;
  typedef logic [LINE_W-1:0] line_t;

  function automatic line_t onehot(input code_t code);
    return line_t'(1) << code;
  endfunction

  // Returns 1 when {par, code} carries an even number of ones.
  function automatic bit even_par(input code_t code, input logic par);
    return ~(^{par, code});
  endfunction

endpackage

// File: rtl/decoder_3to8_if.sv
// Link-side and consumer-side handshake bundle of decoder_3to8.
// Optional DEC_PARITY_EN adds dec_par and err_count.
interface decoder_3to8_if #(
  parameter int CNT_W = 16
);
  import dec_pkg::*;

  code_t            dec_a_value;
  logic             EN_dec;
  logic             RDY_dec;
  line_t            out_yvalue;
  logic             RDY_out;
  logic             EN_out;
  logic [CNT_W-1:0] dec_count;

`ifdef DEC_PARITY_EN
  logic             dec_par;
  logic [CNT_W-1:0] err_count;

  modport master (
    output dec_a_value, EN_dec, dec_par, EN_out,
    input  RDY_dec, out_yvalue, RDY_out, dec_count, err_count
  );

  modport slave (
    input  dec_a_value, EN_dec, dec_par, EN_out,
    output RDY_dec, out_yvalue, RDY_out, dec_count, err_count
  );
`else
  modport master (
    output dec_a_value, EN_dec, EN_out,
    input  RDY_dec, out_yvalue, RDY_out, dec_count
  );

  modport slave (
    input  dec_a_value, EN_dec, EN_out,
    output RDY_dec, out_yvalue, RDY_out, dec_count
  );
`endif

endinterface

// File: rtl/decoder_3to8_fifo.sv
// Small code FIFO: storage, wrapping pointers, occupancy and full/empty flags.
module dec_fifo
  import dec_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  CLK,
  input  logic  RST,
  input  logic  push,
  input  code_t wdata,
  input  logic  pop,
  output code_t rdata,
  output logic  full,
  output logic  empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH + 1);

  code_t         mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [OW-1:0] occ;
  logic          do_push;
  logic          do_pop;

  assign full    = (occ == OW'(DEPTH));
  assign empty   = (occ == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Storage needs no reset; the pointers alone define which entries are live.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/decoder_3to8.sv
// Receive end of the 8-line encoder link: buffers 3-bit codes and rebuilds one-hot lines.
// Optional DEC_PARITY_EN: even-parity gate on pushes with a rejected-word counter.
module decoder_3to8
  import dec_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic           CLK,
  input  logic           RST,
  decoder_3to8_if.slave  bus
);

  code_t            head;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] dec_cnt;

  assign pop = bus.EN_out & ~empty;

`ifdef DEC_PARITY_EN
  logic             par_ok;
  logic [CNT_W-1:0] err_cnt;

  assign par_ok = even_par(bus.dec_a_value, bus.dec_par);
  assign push   = bus.EN_dec & ~full & par_ok;

  always_ff @(posedge CLK) begin
    if (RST) begin
      err_cnt <= '0;
    end else if (bus.EN_dec && !full && !par_ok && err_cnt != '1) begin
      err_cnt <= err_cnt + CNT_W'(1);
    end
  end

  assign bus.err_count = err_cnt;
`else
  assign push = bus.EN_dec & ~full;
`endif

  dec_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (push),
    .wdata (bus.dec_a_value),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      dec_cnt <= '0;
    end else if (pop && dec_cnt != '1) begin
      dec_cnt <= dec_cnt + CNT_W'(1);
    end
  end

  assign bus.RDY_dec    = ~full;
  assign bus.RDY_out    = ~empty;
  assign bus.out_yvalue = empty ? '0 : onehot(head);
  assign bus.dec_count  = dec_cnt;

endmodule

// File: tb/tb_decoder_3to8.sv
// Scoreboard bench for decoder_3to8 (main instance plus a narrow-counter instance).
module tb_decoder_3to8;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  logic [7:0]  exp_q[$];
  logic [15:0] model_cnt = '0;
  logic [15:0] model_err = '0;

  decoder_3to8_if #(.CNT_W(16)) bus  ();
  decoder_3to8_if #(.CNT_W(4))  bus4 ();

  decoder_3to8 #(.DEPTH(DEPTH), .CNT_W(16)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  decoder_3to8 #(.DEPTH(DEPTH), .CNT_W(4)) dut4 (
    .CLK (clk),
    .RST (rst),
    .bus (bus4)
  );

  always #5 clk = ~clk;

  // One clock of stimulus on the main instance; the scoreboard follows what should be accepted.
  task automatic drive(input bit push, input logic [2:0] code, input bit par, input bit pop);
    bit push_ok;
    bit pop_ok;
    pop_ok  = pop && (exp_q.size() > 0);
    push_ok = push && (exp_q.size() < DEPTH);
    bus.EN_dec      = push;
    bus.dec_a_value = code;
    bus.EN_out      = pop;
`ifdef DEC_PARITY_EN
    bus.dec_par = par;
    if (push_ok && (^{par, code})) begin
      push_ok = 1'b0;
      if (model_err != 16'hFFFF) model_err = model_err + 16'd1;
    end
`endif
    @(posedge clk); #1;
    bus.EN_dec = 1'b0;
    bus.EN_out = 1'b0;
    if (pop_ok) begin
      void'(exp_q.pop_front());
      if (model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;
    end
    if (push_ok) exp_q.push_back(8'(1) << code);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.EN_dec = 1'b1; bus.dec_a_value = 3'd4; bus.EN_out = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    bus.EN_dec = 1'b0; bus.EN_out = 1'b0;
    exp_q.delete();
    model_cnt = '0;
    model_err = '0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.RDY_dec !== 1'b1) begin errors++; $display("FAIL reset_rdy_dec got %b want 1", bus.RDY_dec); end
    checks++; if (bus.RDY_out !== 1'b0) begin errors++; $display("FAIL reset_rdy_out got %b want 0", bus.RDY_out); end
    // Put traffic in flight, then reset mid-stream.
    drive(1, 3'd1, 1'b1, 0);
    drive(1, 3'd6, 1'b0, 0);
    drive(1, 3'd2, 1'b1, 1);
    checks++; if (bus.dec_count !== model_cnt) begin errors++; $display("FAIL pre_reset_count got %0d want %0d", bus.dec_count, model_cnt); end
    do_reset();
    checks++; if (bus.RDY_dec !== 1'b1) begin errors++; $display("FAIL flush_rdy_dec got %b want 1", bus.RDY_dec); end
    checks++; if (bus.RDY_out !== 1'b0) begin errors++; $display("FAIL flush_rdy_out got %b want 0", bus.RDY_out); end
    checks++; if (bus.out_yvalue !== 8'h00) begin errors++; $display("FAIL flush_out got %h want 00", bus.out_yvalue); end
    checks++; if (bus.dec_count !== 16'd0) begin errors++; $display("FAIL flush_count got %0d want 0", bus.dec_count); end
`ifdef DEC_PARITY_EN
    checks++; if (bus.err_count !== 16'd0) begin errors++; $display("FAIL flush_err got %0d want 0", bus.err_count); end
`endif
  endtask

  task automatic test_order();
    for (int k = 0; k < 8; k++) begin
      drive(1, 3'(k), ^(3'(k)), 0);
      checks++; if (bus.RDY_out !== 1'b1) begin errors++; $display("FAIL order_rdy k=%0d got %b want 1", k, bus.RDY_out); end
      checks++; if (bus.out_yvalue !== exp_q[0]) begin errors++; $display("FAIL order_out k=%0d got %h want %h", k, bus.out_yvalue, exp_q[0]); end
      drive(0, 3'd0, 1'b0, 1);
    end
    checks++; if (bus.dec_count !== model_cnt) begin errors++; $display("FAIL order_count got %0d want %0d", bus.dec_count, model_cnt); end
    checks++; if (bus.out_yvalue !== 8'h00) begin errors++; $display("FAIL order_empty got %h want 00", bus.out_yvalue); end
  endtask

  task automatic test_full();
    logic [2:0] codes [4];
    codes[0] = 3'd5; codes[1] = 3'd2; codes[2] = 3'd7; codes[3] = 3'd0;
    for (int i = 0; i < 4; i++) drive(1, codes[i], ^codes[i], 0);
    checks++; if (bus.RDY_dec !== 1'b0) begin errors++; $display("FAIL full_rdy_dec got %b want 0", bus.RDY_dec); end
    drive(1, 3'd1, 1'b1, 0);
    checks++; if (bus.out_yvalue !== 8'h20) begin errors++; $display("FAIL full_head got %h want 20", bus.out_yvalue); end
    while (exp_q.size() > 0) begin
      checks++; if (bus.out_yvalue !== exp_q[0]) begin errors++; $display("FAIL full_drain got %h want %h", bus.out_yvalue, exp_q[0]); end
      drive(0, 3'd0, 1'b0, 1);
    end
    checks++; if (bus.RDY_out !== 1'b0) begin errors++; $display("FAIL full_rdy_out got %b want 0", bus.RDY_out); end
    checks++; if (bus.out_yvalue !== 8'h00) begin errors++; $display("FAIL full_out_empty got %h want 00", bus.out_yvalue); end
  endtask

  task automatic test_full_simul();
    for (int i = 0; i < 4; i++) drive(1, 3'(i + 1), ^(3'(i + 1)), 0);
    drive(1, 3'd6, 1'b0, 1);
    checks++; if (bus.RDY_dec !== 1'b1) begin errors++; $display("FAIL simul_rdy_dec got %b want 1", bus.RDY_dec); end
    checks++; if (exp_q.size() != 3) begin errors++; $display("FAIL simul_model_occ got %0d want 3", exp_q.size()); end
    drive(1, 3'd6, 1'b0, 0);
    checks++; if (bus.RDY_dec !== 1'b0) begin errors++; $display("FAIL simul_refill got %b want 0", bus.RDY_dec); end
    while (exp_q.size() > 0) begin
      checks++; if (bus.out_yvalue !== exp_q[0]) begin errors++; $display("FAIL simul_drain got %h want %h", bus.out_yvalue, exp_q[0]); end
      drive(0, 3'd0, 1'b0, 1);
    end
    checks++; if (bus.RDY_out !== 1'b0) begin errors++; $display("FAIL simul_empty got %b want 0", bus.RDY_out); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] c;
    drive(1, 3'd3, 1'b0, 0);
    drive(1, 3'd4, 1'b1, 0);
    for (int i = 0; i < 20; i++) begin
      c = 3'($urandom_range(0, 7));
      checks++; if (bus.out_yvalue !== exp_q[0]) begin errors++; $display("FAIL b2b_out i=%0d got %h want %h", i, bus.out_yvalue, exp_q[0]); end
      drive(1, c, ^c, 1);
      checks++; if (bus.RDY_dec !== (exp_q.size() < DEPTH)) begin errors++; $display("FAIL b2b_rdy i=%0d got %b want %b", i, bus.RDY_dec, exp_q.size() < DEPTH); end
    end
    while (exp_q.size() > 0) begin
      checks++; if (bus.out_yvalue !== exp_q[0]) begin errors++; $display("FAIL b2b_drain got %h want %h", bus.out_yvalue, exp_q[0]); end
      drive(0, 3'd0, 1'b0, 1);
    end
    checks++; if (bus.dec_count !== model_cnt) begin errors++; $display("FAIL b2b_count got %0d want %0d", bus.dec_count, model_cnt); end
  endtask

  task automatic test_saturate();
    logic [3:0] sat;
    logic [2:0] c;
    sat = '0;
    for (int i = 0; i < 17; i++) begin
      c = 3'(i);
      bus4.EN_dec = 1'b1; bus4.dec_a_value = c;
`ifdef DEC_PARITY_EN
      bus4.dec_par = ^c;
`endif
      @(posedge clk); #1;
      bus4.EN_dec = 1'b0;
      checks++; if (bus4.out_yvalue !== (8'(1) << c)) begin errors++; $display("FAIL sat_out i=%0d got %h want %h", i, bus4.out_yvalue, 8'(1) << c); end
      bus4.EN_out = 1'b1;
      @(posedge clk); #1;
      bus4.EN_out = 1'b0;
      if (sat != 4'hF) sat = sat + 4'd1;
      checks++; if (bus4.dec_count !== sat) begin errors++; $display("FAIL sat_count i=%0d got %h want %h", i, bus4.dec_count, sat); end
    end
    checks++; if (bus4.dec_count !== 4'hF) begin errors++; $display("FAIL sat_hold got %h want f", bus4.dec_count); end
  endtask

`ifdef DEC_PARITY_EN
  task automatic test_parity();
    drive(1, 3'd3, 1'b1, 0);
    checks++; if (bus.err_count !== model_err) begin errors++; $display("FAIL par_err got %0d want %0d", bus.err_count, model_err); end
    checks++; if (bus.RDY_out !== 1'b0) begin errors++; $display("FAIL par_drop got %b want 0", bus.RDY_out); end
    drive(1, 3'd3, 1'b0, 0);
    checks++; if (bus.out_yvalue !== 8'h08) begin errors++; $display("FAIL par_good got %h want 08", bus.out_yvalue); end
    checks++; if (bus.err_count !== 16'd1) begin errors++; $display("FAIL par_err_hold got %0d want 1", bus.err_count); end
    drive(0, 3'd0, 1'b0, 1);
  endtask
`endif

  initial begin
    bus.EN_dec = 1'b0; bus.EN_out = 1'b0; bus.dec_a_value = '0;
    bus4.EN_dec = 1'b0; bus4.EN_out = 1'b0; bus4.dec_a_value = '0;
`ifdef DEC_PARITY_EN
    bus.dec_par = 1'b0;
    bus4.dec_par = 1'b0;
`endif
    test_reset();
    test_order();
    test_full();
    test_full_simul();
    test_back_to_back();
    test_saturate();
`ifdef DEC_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
